// File: rtl/dsp_ctrl_pkg.sv
// Shared definitions for the DSP48E1 operand-stage controllers.
//   state_e : sequencer state (normal operation / synchronous-clear window)
//   SEL_B2, SEL_B1 : inmode4 encodings choosing the multiplier source register
package dsp_ctrl_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  localparam logic SEL_B2 = 1'b0;
  localparam logic SEL_B1 = 1'b1;

endpackage

// File: rtl/dual_b_ctrl_if.sv
// Handshake bundle between the slice's operand-fetch logic and dual_b_ctrl.
//   ld_valid / ld_ready   : B-operand load handshake (B1 captures on accept)
//   mul_valid / mul_sel / mul_ready : multiplier operand request, sel 0=B2 1=B1
//   flush_req             : discard all operands and clear the B registers
// master = operand-fetch side, slave = dual_b_ctrl.
interface dual_b_ctrl_if;
  logic ld_valid;
  logic ld_ready;
  logic mul_valid;
  logic mul_sel;
  logic mul_ready;
  logic flush_req;

  modport master (
    output ld_valid, mul_valid, mul_sel, flush_req,
    input  ld_ready, mul_ready
  );

  modport slave (
    input  ld_valid, mul_valid, mul_sel, flush_req,
    output ld_ready, mul_ready
  );
endinterface

// File: rtl/dual_b_ctrl_occ.sv
// Live-operand bookkeeping for the B1->B2 register pair.
//   en        : high in normal operation; low clears v1/v2 and blocks all handshakes
//   ld_valid, mul_valid, mul_sel : requests from the fetch side
//   ld_ready, mul_ready          : handshake acceptance (combinational)
//   ceb1, ceb2                   : B1 / B2 clock enables
//   occ                          : number of live operands
module dual_b_ctrl_occ
  import dsp_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       ld_valid,
  input  logic       mul_valid,
  input  logic       mul_sel,
  output logic       ld_ready,
  output logic       mul_ready,
  output logic       ceb1,
  output logic       ceb2,
  output logic [1:0] occ
);

  logic v1_q, v1_d;
  logic v2_q, v2_d;
  logic pop1, pop2, adv;

  always_comb begin
    pop1      = 1'b0;
    pop2      = 1'b0;
    adv       = 1'b0;
    ld_ready  = 1'b0;
    mul_ready = 1'b0;
    ceb1      = 1'b0;
    ceb2      = 1'b0;
    v1_d      = 1'b0;
    v2_d      = 1'b0;
    if (en) begin
      pop1      = mul_valid & (mul_sel == SEL_B1) & v1_q;
      pop2      = mul_valid & (mul_sel == SEL_B2) & v2_q;
      // B1 slides into B2 only when it is not itself consumed and B2 frees up.
      adv       = v1_q & ~pop1 & (~v2_q | pop2);
      ld_ready  = ~v1_q | adv | pop1;
      mul_ready = pop1 | pop2;
      ceb1      = ld_valid & ld_ready;
      ceb2      = adv;
      v1_d      = ceb1 | (v1_q & ~adv & ~pop1);
      v2_d      = adv | (v2_q & ~pop2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
    end
  end

  assign occ = {1'b0, v1_q} + {1'b0, v2_q};

endmodule

// File: rtl/dual_b_ctrl.sv
// Control sequencer for the two-register (B1 feeding B2) DSP48E1 B input stage.
// Carries no data; drives the stage's enables, clear and multiplier-source select.
//   clk, rst_n : slice clock, asynchronous active-low reset
//   b_if       : load / multiply / flush handshakes (slave side)
//   ceb1, ceb2 : B1 / B2 clock enables
//   rstb       : B1/B2 synchronous clear (also held during reset)
//   inmode4    : multiplier source select (SEL_B2 / SEL_B1)
//   busy       : high during the clear window
//   occ        : live operand count
//   issue_cnt  : completed multiply handshakes, wraps
module dual_b_ctrl
  import dsp_ctrl_pkg::*;
#(
  parameter int unsigned CLR_CYCLES = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  dual_b_ctrl_if.slave     b_if,
  output logic             ceb1,
  output logic             ceb2,
  output logic             rstb,
  output logic             inmode4,
  output logic             busy,
  output logic [1:0]       occ,
  output logic [CNT_W-1:0] issue_cnt
);

  state_e           state_q, state_d;
  logic [3:0]       clr_cnt_q, clr_cnt_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic             run_en;
  logic             ld_ready_w, mul_ready_w;

  // A flush request blocks every handshake in the cycle it is sampled.
  assign run_en = (state_q == ST_RUN) & ~b_if.flush_req;

  dual_b_ctrl_occ u_occ (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (run_en),
    .ld_valid  (b_if.ld_valid),
    .mul_valid (b_if.mul_valid),
    .mul_sel   (b_if.mul_sel),
    .ld_ready  (ld_ready_w),
    .mul_ready (mul_ready_w),
    .ceb1      (ceb1),
    .ceb2      (ceb2),
    .occ       (occ)
  );

  assign b_if.ld_ready  = ld_ready_w;
  assign b_if.mul_ready = mul_ready_w;

  assign inmode4 = ((state_q == ST_RUN) && b_if.mul_valid && (b_if.mul_sel == SEL_B1))
                   ? SEL_B1 : SEL_B2;
  assign busy      = (state_q == ST_FLUSH);
  assign rstb      = ~rst_n | (state_q == ST_FLUSH);
  assign issue_cnt = issue_cnt_q;

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    issue_cnt_d = issue_cnt_q + CNT_W'(mul_ready_w);
    case (state_q)
      ST_RUN: begin
        if (b_if.flush_req) begin
          state_d   = ST_FLUSH;
          clr_cnt_d = 4'(CLR_CYCLES - 1);
        end
      end
      ST_FLUSH: begin
        if (clr_cnt_q == '0) state_d = ST_RUN;
        else                 clr_cnt_d = clr_cnt_q - 4'd1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      clr_cnt_q   <= '0;
      issue_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

endmodule

// File: tb/tb_dual_b_ctrl.sv
module tb_dual_b_ctrl;
  localparam int CLR = 3;
  localparam int CW  = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dual_b_ctrl_if bif();
  logic          ceb1, ceb2, rstb, inmode4, busy;
  logic [1:0]    occ;
  logic [CW-1:0] issue_cnt;

  dual_b_ctrl #(.CLR_CYCLES(CLR), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .b_if(bif),
    .ceb1(ceb1), .ceb2(ceb2), .rstb(rstb), .inmode4(inmode4),
    .busy(busy), .occ(occ), .issue_cnt(issue_cnt)
  );

  // Data registers of the dual B stage, steered by the DUT's controls.
  logic [17:0] b_in, st_b1, st_b2;
  always @(posedge clk) begin
    if (rstb) begin
      st_b1 <= '0;
      st_b2 <= '0;
    end else begin
      if (ceb1) st_b1 <= b_in;
      if (ceb2) st_b2 <= st_b1;
    end
  end

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: two slots with live flags and the operand each holds.
  bit          m_flush, m_v1, m_v2;
  int          m_cnt, m_icnt;
  logic [17:0] m_d1, m_d2;
  bit          n_flush, n_v1, n_v2;
  int          n_cnt, n_icnt;
  logic [17:0] n_d1, n_d2;
  bit          e_ld_ready, e_mul_ready, e_ceb1, e_ceb2, e_inmode4, e_side;

  task automatic model_reset();
    m_flush = 0; m_v1 = 0; m_v2 = 0; m_cnt = 0; m_icnt = 0; m_d1 = '0; m_d2 = '0;
  endtask

  task automatic model_eval(input bit ldv, input bit mv, input bit ms, input bit fl,
                            input logic [17:0] bin);
    bit p1, p2, b1_free, b2_free, slide, ld;
    n_flush = m_flush; n_v1 = m_v1; n_v2 = m_v2; n_cnt = m_cnt; n_icnt = m_icnt;
    n_d1 = m_d1; n_d2 = m_d2;
    e_ld_ready = 0; e_mul_ready = 0; e_ceb1 = 0; e_ceb2 = 0; e_inmode4 = 0; e_side = 1;
    if (m_flush) begin
      n_cnt = m_cnt - 1;
      n_flush = (n_cnt != 0);
    end else if (fl) begin
      e_side = 0;
      n_flush = 1; n_cnt = CLR; n_v1 = 0; n_v2 = 0; n_d1 = '0; n_d2 = '0;
    end else begin
      p1 = mv && ms && m_v1;
      p2 = mv && !ms && m_v2;
      b2_free = !m_v2 || p2;
      slide = m_v1 && !p1 && b2_free;
      b1_free = !m_v1 || slide || p1;
      ld = ldv && b1_free;
      e_ld_ready = b1_free; e_mul_ready = p1 || p2; e_ceb1 = ld; e_ceb2 = slide;
      e_inmode4 = mv && ms;
      if (slide) begin n_v2 = 1; n_d2 = m_d1; end
      else if (p2) n_v2 = 0;
      if (ld) begin n_v1 = 1; n_d1 = bin; end
      else if (slide || p1) n_v1 = 0;
      if (p1 || p2) n_icnt = (m_icnt + 1) % (1 << CW);
    end
  endtask

  task automatic drive(input bit ldv, input bit mv, input bit ms, input bit fl,
                       input logic [17:0] bin);
    bif.ld_valid = ldv; bif.mul_valid = mv; bif.mul_sel = ms; bif.flush_req = fl;
    b_in = bin;
    model_eval(ldv, mv, ms, fl, bin);
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    m_flush = n_flush; m_v1 = n_v1; m_v2 = n_v2; m_cnt = n_cnt; m_icnt = n_icnt;
    m_d1 = n_d1; m_d2 = n_d2;
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst_n = 0;
    bif.ld_valid = 0; bif.mul_valid = 0; bif.mul_sel = 0; bif.flush_req = 0; b_in = '0;
    model_reset();
    #2;
    tests_run++; if (bif.ld_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ld_ready got %b exp 1", bif.ld_ready); end
    tests_run++; if (bif.mul_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_mul_ready got %b exp 0", bif.mul_ready); end
    tests_run++; if ({ceb1, ceb2, inmode4, busy} !== 4'b0) begin tests_failed++; $display("FAIL reset_ctrl got %b exp 0000", {ceb1, ceb2, inmode4, busy}); end
    tests_run++; if (rstb !== 1'b1) begin tests_failed++; $display("FAIL reset_rstb got %b exp 1", rstb); end
    tests_run++; if (occ !== 2'd0 || issue_cnt !== '0) begin tests_failed++; $display("FAIL reset_counts got occ=%0d cnt=%0d exp 0 0", occ, issue_cnt); end
    @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    drive(0, 0, 0, 0, '0);
    tests_run++; if (bif.ld_ready !== 1'b1 || occ !== 2'd0 || rstb !== 1'b0) begin tests_failed++; $display("FAIL post_reset got ld_ready=%b occ=%0d rstb=%b exp 1 0 0", bif.ld_ready, occ, rstb); end
    tick();
  endtask

  task automatic test_fill();
    drive(1, 0, 0, 0, 18'h00011);
    tests_run++; if (ceb1 !== 1'b1 || bif.ld_ready !== 1'b1) begin tests_failed++; $display("FAIL fill1 got ceb1=%b ld_ready=%b exp 1 1", ceb1, bif.ld_ready); end
    tick();
    drive(1, 0, 0, 0, 18'h00022);
    tests_run++; if (ceb1 !== 1'b1 || ceb2 !== 1'b1) begin tests_failed++; $display("FAIL fill2 got ceb1=%b ceb2=%b exp 1 1", ceb1, ceb2); end
    tick();
    drive(0, 0, 0, 0, '0);
    tests_run++; if (occ !== 2'd2 || bif.ld_ready !== 1'b0) begin tests_failed++; $display("FAIL fill_full got occ=%0d ld_ready=%b exp 2 0", occ, bif.ld_ready); end
    tests_run++; if (st_b2 !== 18'h00011 || st_b1 !== 18'h00022) begin tests_failed++; $display("FAIL fill_data got b2=%h b1=%h exp 00011 00022", st_b2, st_b1); end
    tick();
  endtask

  task automatic test_full_pop2_load();
    drive(1, 1, 0, 0, 18'h00033);
    tests_run++; if ({bif.mul_ready, inmode4, ceb2, ceb1} !== 4'b1011) begin tests_failed++; $display("FAIL pop2_load got rdy/inm/ceb2/ceb1=%b exp 1011", {bif.mul_ready, inmode4, ceb2, ceb1}); end
    tick();
    drive(0, 0, 0, 0, '0);
    tests_run++; if (st_b2 !== 18'h00022 || st_b1 !== 18'h00033) begin tests_failed++; $display("FAIL pop2_data got b2=%h b1=%h exp 00022 00033", st_b2, st_b1); end
    tests_run++; if (occ !== 2'd2 || issue_cnt !== 4'd1) begin tests_failed++; $display("FAIL pop2_counts got occ=%0d cnt=%0d exp 2 1", occ, issue_cnt); end
    tick();
  endtask

  task automatic test_pop1();
    drive(0, 1, 1, 0, '0);
    tests_run++; if ({inmode4, bif.mul_ready, ceb2} !== 3'b110) begin tests_failed++; $display("FAIL pop1 got inm/rdy/ceb2=%b exp 110", {inmode4, bif.mul_ready, ceb2}); end
    tick();
    drive(0, 0, 0, 0, '0);
    tests_run++; if (occ !== 2'd1 || st_b2 !== 18'h00022) begin tests_failed++; $display("FAIL pop1_after got occ=%0d b2=%h exp 1 00022", occ, st_b2); end
    tests_run++; if (bif.mul_ready !== 1'b0) begin tests_failed++; $display("FAIL idle_no_req got mul_ready=%b exp 0", bif.mul_ready); end
    tick();
  endtask

  task automatic test_flush();
    drive(1, 0, 0, 0, 18'h00044);
    tick();
    drive(1, 1, 1, 1, 18'h00055);
    tests_run++; if ({bif.ld_ready, bif.mul_ready, ceb1} !== 3'b000) begin tests_failed++; $display("FAIL flush_req_cycle got ldr/mulr/ceb1=%b exp 000", {bif.ld_ready, bif.mul_ready, ceb1}); end
    tick();
    for (int i = 0; i < CLR; i++) begin
      drive(1, 1, 0, (i == 1), 18'h00066);
      tests_run++; if (rstb !== 1'b1 || busy !== 1'b1) begin tests_failed++; $display("FAIL flush_window%0d got rstb=%b busy=%b exp 1 1", i, rstb, busy); end
      tests_run++; if ({bif.ld_ready, bif.mul_ready, ceb1, ceb2, inmode4} !== 5'b0) begin tests_failed++; $display("FAIL flush_quiet%0d got %b exp 00000", i, {bif.ld_ready, bif.mul_ready, ceb1, ceb2, inmode4}); end
      tick();
    end
    drive(0, 0, 0, 0, '0);
    tests_run++; if (busy !== 1'b0 || rstb !== 1'b0 || occ !== 2'd0 || bif.ld_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_exit got busy=%b rstb=%b occ=%0d ldr=%b exp 0 0 0 1", busy, rstb, occ, bif.ld_ready); end
    tests_run++; if (issue_cnt !== 4'd2) begin tests_failed++; $display("FAIL flush_keeps_cnt got %0d exp 2", issue_cnt); end
    tick();
  endtask

  task automatic test_wrap();
    test_reset();
    drive(1, 0, 0, 0, 18'h00100);
    tick();
    for (int i = 0; i < 17; i++) begin
      drive(1, 1, 1, 0, 18'h00101 + 18'(i));
      tests_run++; if (bif.mul_ready !== 1'b1 || ceb1 !== 1'b1 || ceb2 !== 1'b0) begin tests_failed++; $display("FAIL wrap_pop%0d got rdy=%b ceb1=%b ceb2=%b exp 1 1 0", i, bif.mul_ready, ceb1, ceb2); end
      tick();
    end
    drive(0, 0, 0, 0, '0);
    tests_run++; if (issue_cnt !== 4'd1) begin tests_failed++; $display("FAIL wrap_cnt got %0d exp 1", issue_cnt); end
    tick();
  endtask

  task automatic test_random();
    bit ldv, mv, ms, fl;
    for (int i = 0; i < 400; i++) begin
      ldv = ($urandom_range(0, 99) < 60);
      mv  = ($urandom_range(0, 99) < 55);
      ms  = $urandom_range(0, 1) != 0;
      fl  = ($urandom_range(0, 99) < 4);
      drive(ldv, mv, ms, fl, 18'($urandom));
      tests_run++; if (bif.ld_ready !== e_ld_ready || bif.mul_ready !== e_mul_ready || ceb1 !== e_ceb1) begin
        tests_failed++; $display("FAIL rnd_hs cyc %0d got ldr=%b mulr=%b ceb1=%b exp %b %b %b", i, bif.ld_ready, bif.mul_ready, ceb1, e_ld_ready, e_mul_ready, e_ceb1);
      end
      if (e_side) begin
        tests_run++; if (ceb2 !== e_ceb2 || inmode4 !== e_inmode4) begin
          tests_failed++; $display("FAIL rnd_side cyc %0d got ceb2=%b inm=%b exp %b %b", i, ceb2, inmode4, e_ceb2, e_inmode4);
        end
      end
      tests_run++; if (occ !== 2'(m_v1 + m_v2) || busy !== m_flush || rstb !== m_flush || issue_cnt !== CW'(m_icnt)) begin
        tests_failed++; $display("FAIL rnd_state cyc %0d got occ=%0d busy=%b rstb=%b cnt=%0d exp %0d %b %b %0d", i, occ, busy, rstb, issue_cnt, m_v1 + m_v2, m_flush, m_flush, m_icnt);
      end
      if (!m_flush && m_v1) begin
        tests_run++; if (st_b1 !== m_d1) begin tests_failed++; $display("FAIL rnd_b1 cyc %0d got %h exp %h", i, st_b1, m_d1); end
      end
      if (!m_flush && m_v2) begin
        tests_run++; if (st_b2 !== m_d2) begin tests_failed++; $display("FAIL rnd_b2 cyc %0d got %h exp %h", i, st_b2, m_d2); end
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 0;
    test_reset();
    test_fill();
    test_full_pop2_load();
    test_pop1();
    test_flush();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dual_b_ctrl.md
# dual_b_ctrl

Operand sequencer for the dual B input-register stage of the DSP48E1 slice, for the two-register configuration (B1 feeding B2).
- Accepts B-operand loads and multiply-issue requests through valid/ready handshakes.
- Drives the stage's clock enables, synchronous clear and multiplier-source select.
- Tracks which of B1/B2 holds a live operand.
- Sits between the slice's operand-fetch logic and the dual B stage; carries no data, only control.

## Interface
Parameters:
- CLR_CYCLES, 2, cycles the B registers are held in synchronous clear after a flush request (1..15).
- CNT_W, 16, width of the issued-operation counter.

Ports:
- clk  in  1  slice clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ld_valid  in  1  a new B operand is present on the stage's b input this cycle.
- ld_ready  out  1  load accepted this cycle (B1 captures).
- mul_valid  in  1  the multiplier requests an operand this cycle.
- mul_sel  in  1  source select: 0 = B2, 1 = B1.
- mul_ready  out  1  the requested operand is live; it is consumed this cycle.
- flush_req  in  1  discard all operands and clear the B registers.
- ceb1  out  1  B1 clock enable.
- ceb2  out  1  B2 clock enable.
- rstb  out  1  B1/B2 synchronous clear, active-high.
- inmode4  out  1  multiplier source select to the stage.
- busy  out  1  high while in FLUSH.
- occ  out  2  number of live operands (v1 + v2).
- issue_cnt  out  CNT_W  count of completed mul handshakes; wraps modulo 2^CNT_W.

## Operation
- Internal state:
  - valid bits v1 (B1 live) and v2 (B2 live).
  - state machine RUN / FLUSH.
  - clear counter clr_cnt.
- RUN, all terms combinational from the current inputs and v1/v2:
  - pop1 = mul_valid & mul_sel & v1; pop2 = mul_valid & !mul_sel & v2; mul_ready = pop1 | pop2.
  - adv = v1 & !pop1 & (!v2 | pop2). This moves B1 into B2; ceb2 = adv.
  - ld_ready = !v1 | adv | pop1; ceb1 = ld_valid & ld_ready.
  - inmode4 = mul_valid & mul_sel; it is 0 when there is no request.
  - Next v1 = ceb1 | (v1 & !adv & !pop1).
  - Next v2 = adv | (v2 & !pop2).
- Operand order is FIFO through B1→B2. A B1 pop bypasses B2 and does not reorder what is already in B2.
- flush_req sampled in RUN:
  - The FLUSH transition happens at that edge, and v1 and v2 are cleared at that edge.
  - Any load or mul handshake in that same cycle is suppressed: ld_ready and mul_ready are forced low.
- FLUSH:
  - rstb = 1 and busy = 1.
  - ld_ready, mul_ready, ceb1, ceb2 and inmode4 are all 0.
  - clr_cnt counts CLR_CYCLES-1 down to 0, then the block returns to RUN.
  - flush_req during FLUSH is ignored; clr_cnt is not restarted.
- rstb is also asserted while rst_n is low.

## Timing
- Reset (rst_n low, asynchronous):
  - State is RUN; v1, v2, clr_cnt and issue_cnt are 0.
  - Outputs: ld_ready = 1, mul_ready = 0, ceb1 = ceb2 = 0, inmode4 = 0, rstb = 1, busy = 0, occ = 0.
- Handshake latencies:
  - Load: the operand is in B1 one edge after the ld_valid & ld_ready cycle.
  - Advance: the operand is in B2 one edge after the adv cycle.
  - Issue: zero cycles. mul_ready is combinational, and inmode4 is valid in the same cycle.
- Full (v1 & v2): the block accepts a load only with a simultaneous pop of either register.
- Empty: mul_ready = 0 for either select.
- An operand needs a minimum of two edges to reach B2 from an empty stage.
- Simultaneous events in one cycle:
  - pop2 + adv + load are all allowed together.
  - pop1 + load is allowed; no advance happens that cycle.
- FLUSH lasts exactly CLR_CYCLES cycles with rstb high. The first ld_ready = 1 is in cycle CLR_CYCLES+1 after the flush_req edge.
- issue_cnt increments on each mul_ready edge, wrapping from 2^CNT_W−1 to 0. FLUSH does not clear it.

## Structure
- Shared package dsp_ctrl_pkg holds:
  - the state enum (ST_RUN, ST_FLUSH);
  - the inmode4 encodings SEL_B2 = 0 and SEL_B1 = 1.
- One natural sub-module: dual_b_ctrl_occ, holding the v1/v2 bookkeeping and the pop/adv/load equations.
- The FSM, clear counter and issue counter stay in the top.
- Instantiated alongside dual_b with B_REG = 2 and B_CASC_REG = 2.

## Test plan
- Reset then idle: outputs match the reset values listed under Timing; after release, ld_ready = 1 and occ = 0.
- Fill: loads 0x00011 then 0x00022 on consecutive cycles.
  - ceb1 = 1 on both cycles, and ceb2 = 1 on the second.
  - Then occ = 2, ld_ready = 0, and B2 = 0x00011, B1 = 0x00022.
- Full with simultaneous pop2 + load 0x00033:
  - mul_ready = 1, inmode4 = 0, adv = 1, ceb1 = 1.
  - Next cycle B2 = 0x00022, B1 = 0x00033, occ = 2, issue_cnt = 1.
- pop1 with v2 live:
  - mul_sel = 1 gives inmode4 = 1 and mul_ready = 1, with ceb2 = 0.
  - occ drops from 2 to 1, and the B2 contents are unchanged.
- Flush while full with CLR_CYCLES = 3:
  - In the flush_req cycle, a concurrent ld_valid or mul_valid is not accepted.
  - rstb = 1 and busy = 1 for exactly 3 cycles, then occ = 0 and ld_ready = 1.
  - A second flush_req mid-FLUSH does not extend it.
- Counter wrap with CNT_W = 4: 17 pops → issue_cnt = 1.
